// File: rtl/sap_fp_pkg.sv
// Shared types for the SAP-1 front-panel logic: sequencer states, error codes and
// a small helper for sizing the shared counter.
package sap_fp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WRITE,
        READ,
        CHECK
    } fp_state_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
    localparam logic [1:0] ERR_GNT_LOST = 2'b10;
    localparam logic [1:0] ERR_VERIFY   = 2'b11;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fp_mem_sequencer.sv
// Front-panel memory sequencer: builds a byte from keypad nibbles, tracks the edit address,
// and runs each write as request / write pulse / read back / verify / auto-increment.
module fp_mem_sequencer
    import sap_fp_pkg::*;
#(
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned WR_CYCLES   = 4,
    parameter int unsigned GNT_TIMEOUT = 255
) (
    input  logic              sysclk,
    input  logic              reset_n,
    input  logic              prog,
    input  logic              key_valid,
    input  logic [3:0]        key_nibble,
    input  logic              adr_load,
    input  logic [ADDR_W-1:0] adr_sw,
    input  logic              next_pulse,
    input  logic              prev_pulse,
    input  logic              write_pulse,
    output logic              req,
    input  logic              gnt,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] adr,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err_code
);

    // One down-counter serves both the grant timeout and the write pulse width.
    localparam int unsigned CNT_MAX = max_u(GNT_TIMEOUT, WR_CYCLES);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    fp_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [1:0]        err_q, err_d;
    logic              verify_ok;

    assign verify_ok = (mem_rdata == data_q);

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            data_q  <= '0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        data_d  = data_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (prog) begin
                    if (write_pulse) begin
                        state_d = REQ;
                        cnt_d   = CNT_W'(GNT_TIMEOUT);
                    end else begin
                        if (key_valid) begin
                            data_d = {data_q[DATA_W-5:0], key_nibble};
                            err_d  = ERR_NONE;
                        end
                        if (adr_load) begin
                            adr_d = adr_sw;
                            err_d = ERR_NONE;
                        end else if (next_pulse && !prev_pulse) begin
                            adr_d = adr_q + ADDR_W'(1);
                        end else if (prev_pulse && !next_pulse) begin
                            adr_d = adr_q - ADDR_W'(1);
                        end
                    end
                end
            end
            REQ: begin
                if (gnt) begin
                    state_d = WRITE;
                    cnt_d   = CNT_W'(WR_CYCLES - 1);
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WRITE: begin
                if (!gnt) begin
                    state_d = IDLE;
                    err_d   = ERR_GNT_LOST;
                end else if (cnt_q == '0) begin
                    state_d = READ;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            READ: begin
                state_d = CHECK;
            end
            CHECK: begin
                state_d = IDLE;
                if (verify_ok) begin
                    adr_d = adr_q + ADDR_W'(1);
                end else begin
                    err_d = ERR_VERIFY;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Leaving program mode abandons the transaction silently.
        if (!prog && (state_q != IDLE)) begin
            state_d = IDLE;
            adr_d   = adr_q;
            err_d   = err_q;
        end
    end

    assign req       = (state_q != IDLE);
    assign busy      = (state_q != IDLE);
    assign mem_we    = (state_q == WRITE) && gnt && prog;
    assign done      = (state_q == CHECK) && prog && verify_ok;
    assign mem_adr   = adr_q;
    assign mem_wdata = data_q;
    assign adr       = adr_q;
    assign data      = data_q;
    assign err_code  = err_q;

endmodule

// File: tb/tb_fp_mem_sequencer.sv
// Directed bench for fp_mem_sequencer: a cycle-index based transaction model checked every
// cycle, plus literal expectations for the main scenarios.
module tb_fp_mem_sequencer;

    localparam int unsigned AW  = 4;
    localparam int unsigned DW  = 8;
    localparam int unsigned WR  = 4;
    localparam int unsigned GTO = 255;

    logic          sysclk = 1'b0;
    logic          reset_n;
    logic          prog;
    logic          key_valid;
    logic [3:0]    key_nibble;
    logic          adr_load;
    logic [AW-1:0] adr_sw;
    logic          next_pulse;
    logic          prev_pulse;
    logic          write_pulse;
    logic          req;
    logic          gnt;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] adr;
    logic [DW-1:0] data;
    logic          busy;
    logic          done;
    logic [1:0]    err_code;

    int total = 0;
    int bad   = 0;

    fp_mem_sequencer #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .WR_CYCLES  (WR),
        .GNT_TIMEOUT(GTO)
    ) dut (
        .sysclk     (sysclk),
        .reset_n    (reset_n),
        .prog       (prog),
        .key_valid  (key_valid),
        .key_nibble (key_nibble),
        .adr_load   (adr_load),
        .adr_sw     (adr_sw),
        .next_pulse (next_pulse),
        .prev_pulse (prev_pulse),
        .write_pulse(write_pulse),
        .req        (req),
        .gnt        (gnt),
        .mem_adr    (mem_adr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata),
        .adr        (adr),
        .data       (data),
        .busy       (busy),
        .done       (done),
        .err_code   (err_code)
    );

    always #5 sysclk = ~sysclk;

    // Memory behind the programming port; optionally flips bit 0 when 0x55 is written.
    logic          corrupt_en;
    logic [DW-1:0] mem [16];

    always @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            mem_rdata <= '0;
        end else begin
            if (mem_we) mem[mem_adr] <= (corrupt_en && mem_wdata == 8'h55) ? (mem_wdata ^ 8'h01)
                                                                           : mem_wdata;
            mem_rdata <= mem[mem_adr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a transaction is tracked by t (cycles since entering request) and g (t at which
    // grant was first seen); every output follows from those offsets.
    int            cyc      = 0;
    int            we_cnt   = 0;
    int            req_cnt  = 0;
    int            done_cnt = 0;
    int            done_cyc = -1;
    logic [AW-1:0] m_adr;
    logic [DW-1:0] m_data;
    logic [1:0]    m_err;
    logic          m_busy;
    int            m_t;
    int            m_g;

    initial begin
        logic e_we, e_done, ok;
        forever begin
            @(negedge sysclk);
            if (!reset_n) begin
                m_adr = '0; m_data = '0; m_err = 2'b00; m_busy = 1'b0; m_t = 0; m_g = -1;
            end
            ok     = !(corrupt_en && m_data == 8'h55);
            e_we   = m_busy && m_g >= 0 && m_t > m_g && m_t <= m_g + int'(WR) && gnt && prog;
            e_done = m_busy && m_g >= 0 && m_t == m_g + int'(WR) + 2 && prog && ok;
            chk("req", 32'(req), 32'(m_busy));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("mem_we", 32'(mem_we), 32'(e_we));
            chk("done", 32'(done), 32'(e_done));
            chk("adr", 32'(adr), 32'(m_adr));
            chk("mem_adr", 32'(mem_adr), 32'(m_adr));
            chk("data", 32'(data), 32'(m_data));
            chk("mem_wdata", 32'(mem_wdata), 32'(m_data));
            chk("err_code", 32'(err_code), 32'(m_err));
            if (mem_we) we_cnt++;
            if (req) req_cnt++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (reset_n) begin
                if (!m_busy) begin
                    if (prog) begin
                        if (write_pulse) begin
                            m_busy = 1'b1; m_t = 0; m_g = -1;
                        end else begin
                            if (key_valid) begin m_data = {m_data[3:0], key_nibble}; m_err = 0; end
                            if (adr_load) begin m_adr = adr_sw; m_err = 0; end
                            else if (next_pulse && !prev_pulse) m_adr = m_adr + 1'b1;
                            else if (prev_pulse && !next_pulse) m_adr = m_adr - 1'b1;
                        end
                    end
                end else begin
                    if (!prog) m_busy = 1'b0;
                    else if (m_g < 0) begin
                        if (gnt) m_g = m_t;
                        else if (m_t == int'(GTO)) begin m_busy = 1'b0; m_err = 2'b01; end
                    end else if (m_t <= m_g + int'(WR)) begin
                        if (!gnt) begin m_busy = 1'b0; m_err = 2'b10; end
                    end else if (m_t == m_g + int'(WR) + 2) begin
                        m_busy = 1'b0;
                        if (ok) m_adr = m_adr + 1'b1; else m_err = 2'b11;
                    end
                    m_t++;
                end
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic key(input logic [3:0] n);
        key_valid = 1'b1; key_nibble = n; tick(); key_valid = 1'b0;
    endtask

    task automatic load(input logic [AW-1:0] a);
        adr_load = 1'b1; adr_sw = a; tick(); adr_load = 1'b0;
    endtask

    task automatic step(input logic nx, input logic pv);
        next_pulse = nx; prev_pulse = pv; tick(); next_pulse = 1'b0; prev_pulse = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy && n < limit) begin tick(); n++; end
        if (busy) chk("wait_idle_timeout", 32'(busy), 32'd0);
    endtask

    int wp_cyc, we0, req0, done0;

    task automatic start_write();
        we0 = we_cnt; req0 = req_cnt; done0 = done_cnt; wp_cyc = cyc;
        write_pulse = 1'b1; tick(); write_pulse = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; prog = 1'b1; gnt = 1'b1; corrupt_en = 1'b0;
        key_valid = 1'b0; key_nibble = '0; adr_load = 1'b0; adr_sw = '0;
        next_pulse = 1'b0; prev_pulse = 1'b0; write_pulse = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        chk("reset_adr", 32'(adr), 32'd0);
        chk("reset_data", 32'(data), 32'd0);
        chk("reset_req", 32'(req), 32'd0);

        // Keys 3, A; write at 5 with grant tied high.
        load(4'd5);
        key(4'h3);
        key(4'hA);
        chk("data_3a", 32'(data), 32'h3A);
        start_write();
        key(4'h7);                          // ignored while busy
        wait_idle(20);
        chk("we_cycles", 32'(we_cnt - we0), 32'd4);
        chk("done_latency", 32'(done_cyc - wp_cyc), 32'd7);
        chk("mem5", 32'(mem[5]), 32'h3A);
        chk("adr_inc", 32'(adr), 32'd6);

        // Address wrap on verified write, prev at 0, next+prev together.
        load(4'd15);
        start_write();
        wait_idle(20);
        chk("wrap_adr", 32'(adr), 32'd0);
        step(1'b0, 1'b1);
        chk("prev_wrap", 32'(adr), 32'd15);
        step(1'b1, 1'b1);
        chk("both_steps", 32'(adr), 32'd15);
        step(1'b1, 1'b0);
        chk("next_wrap", 32'(adr), 32'd0);

        // Grant never arrives.
        gnt = 1'b0;
        start_write();
        wait_idle(300);
        chk("timeout_req_cycles", 32'(req_cnt - req0), 32'd256);
        chk("timeout_err", 32'(err_code), 32'd1);
        chk("timeout_no_we", 32'(we_cnt - we0), 32'd0);
        key(4'h5);
        chk("key_clears_err", 32'(err_code), 32'd0);

        // Grant lost in the second write cycle.
        gnt = 1'b1;
        load(4'd9);
        start_write();
        tick(); tick();
        gnt = 1'b0;
        #1;
        chk("gnt_lost_we_low", 32'(mem_we), 32'd0);
        tick();
        chk("gnt_lost_err", 32'(err_code), 32'd2);
        chk("gnt_lost_adr", 32'(adr), 32'd9);
        chk("gnt_lost_we_cycles", 32'(we_cnt - we0), 32'd1);
        gnt = 1'b1;

        // Verify mismatch.
        load(4'd2);
        key(4'h5);
        key(4'h5);
        corrupt_en = 1'b1;
        start_write();
        wait_idle(20);
        chk("verify_err", 32'(err_code), 32'd3);
        chk("verify_adr", 32'(adr), 32'd2);
        chk("verify_no_done", 32'(done_cnt - done0), 32'd0);
        corrupt_en = 1'b0;

        // prog drops during WRITE.
        load(4'd4);
        start_write();
        tick();
        prog = 1'b0;
        tick();
        chk("prog_busy", 32'(busy), 32'd0);
        chk("prog_req", 32'(req), 32'd0);
        chk("prog_err", 32'(err_code), 32'd0);
        chk("prog_adr", 32'(adr), 32'd4);
        prog = 1'b1;

        // Reset pulse during READ.
        start_write();
        repeat (5) tick();
        reset_n = 1'b0;
        #1;
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_adr", 32'(adr), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("rst_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
